riscv_ex_hazard_scoreboard: RTL and testbench

RISCV_EX_HAZARD_SCOREBOARD -- requirements
Module: riscv_ex_hazard_scoreboard

---
 rtl/riscv_ex_hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_riscv_ex_hazard_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_hazard_scoreboard.sv
// EX hazard scoreboard: tracks in-flight producers for forwarding and load-use
// stalls, plus one outstanding long (mul/div) op; counts stall cycles.
// Ports: i_clk, i_rst_n; ID request fields (i_id_*), i_long_done, i_flush;
// outputs o_stall, o_fwd1_sel/o_fwd2_sel (0=RF, k=entry k), o_long_busy,
// o_stall_cnt.
module riscv_ex_hazard_scoreboard #(
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int STALL_CNT_WIDTH = 16,
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_id_valid,
  input  logic [4:0]                 i_id_rs1_addr,
  input  logic [4:0]                 i_id_rs2_addr,
  input  logic                       i_id_rs1_used,
  input  logic                       i_id_rs2_used,
  input  logic [4:0]                 i_id_rd_addr,
  input  logic                       i_id_rd_write,
  input  logic                       i_id_is_load,
  input  logic                       i_id_is_long,
  input  logic                       i_long_done,
  input  logic                       i_flush,
  output logic                       o_stall,
  output logic [SEL_W-1:0]           o_fwd1_sel,
  output logic [SEL_W-1:0]           o_fwd2_sel,
  output logic                       o_long_busy,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_cnt
);

  localparam int N = NUM_FWD_STAGES;

  logic [N:1] e_valid;
  logic [N:1] e_write;
  logic [N:1] e_load;
  logic [4:0] e_rd [N:1];

  logic       busy;
  logic [4:0] busy_rd;
  logic [STALL_CNT_WIDTH-1:0] cnt;

  logic [SEL_W-1:0] sel1;
  logic [SEL_W-1:0] sel2;
  logic lu1;
  logic lu2;
  logic busy_eff;
  logic rd_hit;
  logic long_haz;
  logic stall;
  logic issue;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    lu1 = 1'b0;
    lu2 = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (i_id_rs1_used && i_id_rs1_addr != 5'd0 &&
          e_valid[k] && e_write[k] &&
          e_rd[k] == i_id_rs1_addr) begin
        sel1 = SEL_W'(k);
        lu1 = e_load[k] && (k <= LOAD_LATENCY);
      end
      if (i_id_rs2_used && i_id_rs2_addr != 5'd0 &&
          e_valid[k] && e_write[k] &&
          e_rd[k] == i_id_rs2_addr) begin
        sel2 = SEL_W'(k);
        lu2 = e_load[k] && (k <= LOAD_LATENCY);
      end
    end
  end

  // A completing long op releases its hazard in the same cycle.
  assign busy_eff = busy & ~i_long_done;

  assign rd_hit = (busy_rd != 5'd0) &
    ((i_id_rs1_used & (i_id_rs1_addr == busy_rd)) |
     (i_id_rs2_used & (i_id_rs2_addr == busy_rd)) |
     (i_id_rd_write & (i_id_rd_addr == busy_rd)));

  assign long_haz = busy_eff & (i_id_is_long | rd_hit);
  assign stall = i_id_valid & (lu1 | lu2 | long_haz) & ~i_flush;
  assign issue = i_id_valid & ~stall & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_valid <= '0;
      e_write <= '0;
      e_load <= '0;
      for (int k = 1; k <= N; k++) e_rd[k] <= '0;
      busy <= 1'b0;
      busy_rd <= '0;
      cnt <= '0;
    end else begin
      if (i_flush) begin
        e_valid <= '0;
      end else begin
        for (int k = N; k >= 2; k--) begin
          e_valid[k] <= e_valid[k-1];
          e_write[k] <= e_write[k-1];
          e_load[k] <= e_load[k-1];
          e_rd[k] <= e_rd[k-1];
        end
        // Long ops write back via the done path, never via forwarding.
        e_valid[1] <= issue & ~i_id_is_long;
        e_write[1] <= i_id_rd_write;
        e_load[1] <= i_id_is_load;
        e_rd[1] <= i_id_rd_addr;
      end
      if (issue && i_id_is_long) begin
        busy <= 1'b1;
        busy_rd <= i_id_rd_addr;
      end else if (i_long_done) begin
        busy <= 1'b0;
      end
      if (stall && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign o_stall = stall;
  assign o_fwd1_sel = sel1;
  assign o_fwd2_sel = sel2;
  assign o_long_busy = busy;
  assign o_stall_cnt = cnt;

endmodule

// File: tb/tb_riscv_ex_hazard_scoreboard.sv
// Bench for riscv_ex_hazard_scoreboard: directed scenarios then random
// traffic against a queue-based producer-history model.
module tb_riscv_ex_hazard_scoreboard;

  localparam int N = 2;
  localparam int LL = 1;
  localparam int CW = 5;
  localparam int SW = $clog2(N + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic u1 = 1'b0;
  logic u2 = 1'b0;
  logic [4:0] rd = '0;
  logic wr = 1'b0;
  logic ld = 1'b0;
  logic lg = 1'b0;
  logic done = 1'b0;
  logic flush = 1'b0;
  logic stall;
  logic [SW-1:0] fwd1;
  logic [SW-1:0] fwd2;
  logic lbusy;
  logic [CW-1:0] scnt;

  always #5 clk = ~clk;

  riscv_ex_hazard_scoreboard #(
    .NUM_FWD_STAGES(N),
    .LOAD_LATENCY(LL),
    .STALL_CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_id_valid(id_valid),
    .i_id_rs1_addr(rs1),
    .i_id_rs2_addr(rs2),
    .i_id_rs1_used(u1),
    .i_id_rs2_used(u2),
    .i_id_rd_addr(rd),
    .i_id_rd_write(wr),
    .i_id_is_load(ld),
    .i_id_is_long(lg),
    .i_long_done(done),
    .i_flush(flush),
    .o_stall(stall),
    .o_fwd1_sel(fwd1),
    .o_fwd2_sel(fwd2),
    .o_long_busy(lbusy),
    .o_stall_cnt(scnt)
  );

  typedef struct {
    bit v;
    bit [4:0] rd;
    bit wr;
    bit ld;
  } ent_t;

  // hist[0] = issued last cycle, hist[N-1] = oldest still tracked.
  ent_t hist[$];
  bit mbusy;
  bit [4:0] mbrd;
  int mcnt;
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    ent_t e;
    e = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back(e);
    mbusy = 1'b0;
    mbrd = '0;
    mcnt = 0;
  endtask

  function automatic int msel(input bit [4:0] rs, input bit used);
    if (!used || rs == 0) return 0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].v && hist[i].wr && hist[i].rd == rs) return i + 1;
    return 0;
  endfunction

  function automatic bit mstall();
    int s1;
    int s2;
    bit lu;
    bit lh;
    s1 = msel(rs1, u1);
    s2 = msel(rs2, u2);
    lu = (s1 != 0 && s1 <= LL && hist[s1-1].ld) ||
         (s2 != 0 && s2 <= LL && hist[s2-1].ld);
    lh = mbusy && !done &&
         (lg || (mbrd != 0 && ((u1 && rs1 == mbrd) ||
                               (u2 && rs2 == mbrd) ||
                               (wr && rd == mbrd))));
    return id_valid && (lu || lh) && !flush;
  endfunction

  task automatic set(input bit v, input bit [4:0] a1, input bit e1,
                     input bit [4:0] a2, input bit e2,
                     input bit [4:0] d, input bit w, input bit l,
                     input bit g, input bit dn, input bit f);
    id_valid = v;
    rs1 = a1;
    u1 = e1;
    rs2 = a2;
    u2 = e2;
    rd = d;
    wr = w;
    ld = l;
    lg = g;
    done = dn;
    flush = f;
    #1;
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check all outputs against the model, then clock once and advance it.
  task automatic step();
    bit st;
    bit iss;
    ent_t e;
    st = mstall();
    chk("stall", stall, st);
    chk("fwd1", fwd1, msel(rs1, u1));
    chk("fwd2", fwd2, msel(rs2, u2));
    chk("busy", lbusy, mbusy);
    chk("cnt", scnt, mcnt);
    @(posedge clk);
    iss = id_valid && !st && !flush;
    if (flush) begin
      for (int i = 0; i < N; i++) hist[i].v = 1'b0;
    end else begin
      e = '{v: iss && !lg, rd: rd, wr: wr, ld: ld};
      hist.push_front(e);
      void'(hist.pop_back());
    end
    if (iss && lg) begin
      mbusy = 1'b1;
      mbrd = rd;
    end else if (done) begin
      mbusy = 1'b0;
    end
    if (st && mcnt < CMAX) mcnt++;
    @(negedge clk);
  endtask

  initial begin
    mreset();
    @(negedge clk);
    idle();
    chk("rst_stall", stall, 0);
    chk("rst_fwd1", fwd1, 0);
    chk("rst_busy", lbusy, 0);
    chk("rst_cnt", scnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x5 forwarded from entry 1, then from entry 2 across a bubble.
    set(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); step();
    set(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("add_fwd1", fwd1, 1);
    chk("add_nostall", stall, 0);
    step();
    set(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); step();
    idle(); step();
    set(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("add_fwd2", fwd1, 2);
    step();

    // LW x7 then use in rs2: one stall cycle, then forward from entry 2.
    set(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); step();
    set(1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 0);
    chk("lu_stall", stall, 1);
    step();
    chk("lu_release", stall, 0);
    chk("lu_fwd2", fwd2, 2);
    step();
    idle();
    chk("lu_cnt", scnt, 1);

    // Two writers of x3: youngest wins; x0 never forwards.
    set(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); step();
    set(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); step();
    set(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x3_young", fwd1, 1);
    step();
    set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();
    set(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("x0_fwd1", fwd1, 0);
    chk("x0_fwd2", fwd2, 0);
    step();

    // MUL x9, dependent SUB stalls until done.
    set(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0); step();
    set(1, 9, 1, 0, 0, 4, 1, 0, 0, 0, 0);
    chk("mul_busy", lbusy, 1);
    chk("mul_stall", stall, 1);
    step(); step(); step();
    set(1, 9, 1, 0, 0, 4, 1, 0, 0, 1, 0);
    chk("mul_done_stall", stall, 0);
    step();
    idle();
    chk("mul_busy_clr", lbusy, 0);

    // Back-to-back long ops: done same cycle lets the next one issue.
    set(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0); step();
    set(1, 0, 0, 0, 0, 10, 1, 0, 1, 1, 0);
    chk("long_done_pri", stall, 0);
    step();
    idle();
    chk("long_rebusy", lbusy, 1);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();

    // Flush during a load-use stall.
    set(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); step();
    set(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    chk("fl_pre", stall, 1);
    set(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1);
    chk("fl_stall", stall, 0);
    step();
    set(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    chk("fl_fwd2", fwd2, 0);
    chk("fl_nostall", stall, 0);
    step();

    // Reset mid-stall with a long op outstanding; late done is harmless.
    set(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0); step();
    set(1, 9, 1, 0, 0, 4, 1, 0, 0, 0, 0); step();
    rst_n = 1'b0;
    #1;
    mreset();
    chk("mrst_stall", stall, 0);
    chk("mrst_busy", lbusy, 0);
    chk("mrst_cnt", scnt, 0);
    chk("mrst_fwd1", fwd1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    idle();
    chk("late_done", lbusy, 0);

    // Saturate the stall counter.
    set(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0); step();
    set(1, 9, 1, 0, 0, 4, 1, 0, 0, 0, 0);
    for (int i = 0; i < CMAX + 6; i++) step();
    chk("cnt_sat", scnt, CMAX);
    set(1, 9, 1, 0, 0, 4, 1, 0, 0, 1, 0); step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set($urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
